operand_streamer: RTL and testbench
===================================

# operand_streamer

Host-side transmitter for the convolution core's operand handshake. It walks the same six-deep loop nest the core consumes: x outer, then y, ch_in, ch_out, ky, kx inner. For each step it fetches one activation and one weight from external synchronous memories and presents them as an aligned pair on the a/b valid/ready interface. Out-of-bounds kernel taps produce zero activations ("same" padding), so the core sees exactly W·H·C_in·C_out·K·K pairs.

## Interface
- FEATURE_MAP_WIDTH, 1024, W
- FEATURE_MAP_HEIGHT, 1024, H
- INPUT_NB_CHANNELS, 64, C_in
- OUTPUT_NB_CHANNELS, 64, C_out
- KERNEL_SIZE, 3, K (odd)
- DATA_WIDTH, 16, operand width
- ADDR_WIDTH, 32, memory address width
- clk  in  1  clock
- arst_n_in  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; ignored unless IDLE
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the final transfer
- act_re  out  1  activation read enable
- act_addr  out  ADDR_WIDTH  activation read address
- act_rdata  in  DATA_WIDTH  activation data, valid 1 cycle after act_re
- wgt_re  out  1  weight read enable
- wgt_addr  out  ADDR_WIDTH  weight read address
- wgt_rdata  in  DATA_WIDTH  weight data, valid 1 cycle after wgt_re
- a_valid, b_valid  out  1  operand pair valid; always identical
- a_data, b_data  out  DATA_WIDTH  activation / weight operand
- a_ready, b_ready  in  1  consumer ready

## Operation
- States: IDLE, STREAM, DRAIN.
  - IDLE→STREAM on start.
  - STREAM→DRAIN in the cycle after the last pair is issued.
  - DRAIN→IDLE when the buffer is empty; done=1 in that cycle.
- Transfer condition: a_valid && a_ready && b_ready. Exactly one pair pops per transfer.
- Issue slot: one loop step advances per slot. A slot is taken in STREAM when credit allows: buffered + in-flight − pop < 2.
- Activation source coordinates: yy = y + ky − (K−1)/2 and xx = x + kx − (K−1)/2, computed signed 33-bit.
- In-bounds tap (0 ≤ xx < W and 0 ≤ yy < H):
  - act_re=1.
  - act_addr = (yy·W + xx)·C_in + ch_in.
- Padded tap: act_re=0, and the slot carries a pad flag so the buffered activation is 0.
- Weights: wgt_re=1 every slot; wgt_addr = ((ch_out·C_in + ch_in)·K + ky)·K + kx.
- Address width: all products are unsigned and truncated to ADDR_WIDTH.
- Counter wrap: each counter wraps to 0 at its last value and carries into the next-outer counter, matching the consumer's order.
- Buffer: 2-entry FIFO of {act, wgt}. Write one cycle after issue; pop on transfer.
- Reset values: all outputs 0, state IDLE, counters 0, FIFO empty.
- Reset mid-operation: returns immediately to IDLE. In-flight reads are discarded and no done pulse is produced.
- start during STREAM or DRAIN has no effect.

## Timing
- start in cycle 0: STREAM and first issue in cycle 1; a_valid=1 in cycle 2.
- Issue-to-valid latency is 1 cycle.
- Throughput is 1 pair/cycle when ready is held high.
- Backpressure: a_valid/data stay stable until transferred. Issue stalls when 2 entries are outstanding.
- Simultaneous pop and write in the same cycle is legal at occupancy 1 or 2 (after the pop).
- done follows the final transfer by exactly 1 cycle. busy drops in the done cycle.
- act_re/wgt_re are never high outside STREAM.

## Structure
- Package operand_streamer_pkg:
  - state enum {IDLE, STREAM, DRAIN}.
  - loop-counter struct {x, y, ch_in, ch_out, ky, kx}, 32 bits each.
  - function computing the pad flag.
- Sub-module stream_fifo2 (parameter WIDTH):
  - 2-entry FIFO with push/pop/full/empty.
  - Simultaneous push/pop supported.

## Test plan
- Common config: W=H=4, C_in=C_out=2, K=3, ready held 1.
- Full run: exactly 576 transfers, then done, with no gap after the first valid.
- First pair: padded.
  - act_re=0, a_data=0, wgt_addr=0.
  - Pair 4 (ky=1, kx=1): act_addr=0, wgt_addr=4.
- Corner padding: at x=3, y=3, the kx=2 and ky=2 taps carry a_data=0 and act_re=0. At x=0, y=0, ch_in=1, the tap ky=1, kx=1 reads act_addr=1.
- Random ready toggling (50%):
  - Sequence is identical to the always-ready run.
  - Data is stable while valid && !ready.
  - Never more than 2 reads are outstanding.
- start pulsed during STREAM: ignored, and the count stays 576.
- arst_n_in low after 100 transfers:
  - All outputs 0 next edge, with no done.
  - A new start restarts from pair 0.

Source files
------------

// File: rtl/operand_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : operand_streamer_pkg
// Description : Shared types and helpers for the operand streamer: state
//               encoding, the six-deep loop-counter record and the
//               padding-tap test.
// Revision    : 1.0  initial release
// ============================================================================
package operand_streamer_pkg;

  // Controller states; encoding fixed so it is stable across revisions
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  // Loop position, ordered outer (x) to inner (kx)
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch_in;
    logic [31:0] ch_out;
    logic [31:0] ky;
    logic [31:0] kx;
  } loop_cnt_t;

  // Source coordinate of a kernel tap, centred on the output pixel
  function automatic logic signed [32:0] tap_coord(input logic [31:0] pos,
                                                   input logic [31:0] tap,
                                                   input int unsigned k);
    return $signed({1'b0, pos}) + $signed({1'b0, tap}) - $signed(33'((k - 1) / 2));
  endfunction

  // A tap is padding when its source pixel lies outside the feature map
  function automatic logic is_pad(input logic signed [32:0] xx,
                                  input logic signed [32:0] yy,
                                  input int unsigned w,
                                  input int unsigned h);
    return (xx < 33'sd0) || (yy < 33'sd0) ||
           (xx >= $signed(33'(w))) || (yy >= $signed(33'(h)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo2
// Description : Two-entry synchronous FIFO with simultaneous push/pop and a
//               combinational head output.
// Revision    : 1.0  initial release
// ============================================================================
module stream_fifo2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full FIFO is only accepted when a pop frees a slot
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && !empty;
  assign full      = (r_count == 2'd2);
  assign empty     = (r_count == 2'd0);
  assign rdata     = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_streamer.sv
`default_nettype none
// ============================================================================
// Module      : operand_streamer
// Description : Walks the convolution loop nest, fetches activation/weight
//               pairs from synchronous memories (zero for padded taps) and
//               streams them on the a/b valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module operand_streamer
  import operand_streamer_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  arst_n_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  act_re,
  output logic [ADDR_WIDTH-1:0] act_addr,
  input  logic [DATA_WIDTH-1:0] act_rdata,
  output logic                  wgt_re,
  output logic [ADDR_WIDTH-1:0] wgt_addr,
  input  logic [DATA_WIDTH-1:0] wgt_rdata,
  output logic                  a_valid,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_ready,
  output logic                  b_valid,
  output logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_ready
);

  localparam logic [31:0] c_x_last    = 32'(FEATURE_MAP_WIDTH - 1);
  localparam logic [31:0] c_y_last    = 32'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [31:0] c_cin_last  = 32'(INPUT_NB_CHANNELS - 1);
  localparam logic [31:0] c_cout_last = 32'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [31:0] c_k_last    = 32'(KERNEL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] c_w_a   = ADDR_WIDTH'(FEATURE_MAP_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_cin_a = ADDR_WIDTH'(INPUT_NB_CHANNELS);
  localparam logic [ADDR_WIDTH-1:0] c_k_a   = ADDR_WIDTH'(KERNEL_SIZE);

  state_e                    r_state;
  state_e                    w_state_next;
  loop_cnt_t                 r_cnt;
  loop_cnt_t                 w_cnt_next;
  logic                      r_inflight;
  logic                      r_pad;
  logic signed [32:0]        w_xx;
  logic signed [32:0]        w_yy;
  logic                      w_pad;
  logic                      w_last;
  logic                      w_issue;
  logic                      w_xfer;
  logic [2:0]                w_occ;
  logic [1:0]                w_fifo_cnt;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic [2*DATA_WIDTH-1:0]   w_head_in;
  logic [2*DATA_WIDTH-1:0]   w_fifo_rdata;
  logic [2*DATA_WIDTH-1:0]   w_head;
  logic [ADDR_WIDTH-1:0]     w_act_addr;
  logic [ADDR_WIDTH-1:0]     w_wgt_addr;

  // Tap geometry for the current loop position
  assign w_xx  = tap_coord(r_cnt.x, r_cnt.kx, KERNEL_SIZE);
  assign w_yy  = tap_coord(r_cnt.y, r_cnt.ky, KERNEL_SIZE);
  assign w_pad = is_pad(w_xx, w_yy, FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT);

  assign w_last = (r_cnt.x == c_x_last) && (r_cnt.y == c_y_last) &&
                  (r_cnt.ch_in == c_cin_last) && (r_cnt.ch_out == c_cout_last) &&
                  (r_cnt.ky == c_k_last) && (r_cnt.kx == c_k_last);

  // Logical queue = FIFO entries plus the read still in flight this cycle
  assign w_xfer     = a_valid && a_ready && b_ready;
  assign w_fifo_cnt = {w_full, !w_empty && !w_full};
  assign w_occ      = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_xfer};
  assign w_issue    = (r_state == STREAM) && (w_occ < 3'd2);

  assign w_act_addr = (ADDR_WIDTH'(w_yy) * c_w_a + ADDR_WIDTH'(w_xx)) * c_cin_a +
                      ADDR_WIDTH'(r_cnt.ch_in);
  assign w_wgt_addr = ((ADDR_WIDTH'(r_cnt.ch_out) * c_cin_a + ADDR_WIDTH'(r_cnt.ch_in)) *
                       c_k_a + ADDR_WIDTH'(r_cnt.ky)) * c_k_a + ADDR_WIDTH'(r_cnt.kx);

  assign act_re   = w_issue && !w_pad;
  assign wgt_re   = w_issue;
  assign act_addr = act_re ? w_act_addr : '0;
  assign wgt_addr = wgt_re ? w_wgt_addr : '0;

  // Memory data arriving now; padded taps substitute a zero activation
  assign w_head_in = {(r_pad ? {DATA_WIDTH{1'b0}} : act_rdata), wgt_rdata};

  // An arriving pair bypasses an empty FIFO and is stored only if not taken
  assign w_push = r_inflight && !(w_empty && w_xfer);
  assign w_pop  = w_xfer && !w_empty;
  assign w_head = w_empty ? w_head_in : w_fifo_rdata;

  assign a_valid = !w_empty || r_inflight;
  assign b_valid = a_valid;
  assign a_data  = a_valid ? w_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign b_data  = a_valid ? w_head[DATA_WIDTH-1:0] : '0;

  assign done = (r_state == DRAIN) && w_empty && !r_inflight;
  assign busy = (r_state != IDLE) && !done;

  stream_fifo2 #(
    .WIDTH (2 * DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .push      (w_push),
    .pop       (w_pop),
    .wdata     (w_head_in),
    .rdata     (w_fifo_rdata),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Loop nest advance: kx innermost, each counter carries into the next outer
  always_comb begin
    w_cnt_next = r_cnt;
    if (r_cnt.kx != c_k_last) begin
      w_cnt_next.kx = r_cnt.kx + 32'd1;
    end else begin
      w_cnt_next.kx = '0;
      if (r_cnt.ky != c_k_last) begin
        w_cnt_next.ky = r_cnt.ky + 32'd1;
      end else begin
        w_cnt_next.ky = '0;
        if (r_cnt.ch_out != c_cout_last) begin
          w_cnt_next.ch_out = r_cnt.ch_out + 32'd1;
        end else begin
          w_cnt_next.ch_out = '0;
          if (r_cnt.ch_in != c_cin_last) begin
            w_cnt_next.ch_in = r_cnt.ch_in + 32'd1;
          end else begin
            w_cnt_next.ch_in = '0;
            if (r_cnt.y != c_y_last) begin
              w_cnt_next.y = r_cnt.y + 32'd1;
            end else begin
              w_cnt_next.y = '0;
              w_cnt_next.x = (r_cnt.x != c_x_last) ? r_cnt.x + 32'd1 : '0;
            end
          end
        end
      end
    end
  end

  // Next-state logic for the stream controller
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = STREAM;
      STREAM:  if (w_issue && w_last) w_state_next = DRAIN;
      DRAIN:   if (done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, loop counters and the one-deep in-flight read tracker
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_inflight <= 1'b0;
      r_pad      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      r_pad      <= w_issue && w_pad;
      if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= w_cnt_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_streamer
// Description : Self-checking bench for operand_streamer on a 4x4x2x2 K=3
//               configuration against a loop-nest reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_operand_streamer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CI = 2;
  localparam int CO = 2;
  localparam int K  = 3;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int N  = W * H * CI * CO * K * K;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, act_re, wgt_re, a_valid, b_valid;
  logic [AW-1:0] act_addr, wgt_addr;
  logic [DW-1:0] act_rdata = '0, wgt_rdata = '0, a_data, b_data;
  logic          a_ready = 1'b1, b_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  operand_streamer #(
    .FEATURE_MAP_WIDTH  (W),
    .FEATURE_MAP_HEIGHT (H),
    .INPUT_NB_CHANNELS  (CI),
    .OUTPUT_NB_CHANNELS (CO),
    .KERNEL_SIZE        (K),
    .DATA_WIDTH         (DW),
    .ADDR_WIDTH         (AW)
  ) dut (
    .clk       (clk),
    .arst_n_in (arst_n_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .act_re    (act_re),
    .act_addr  (act_addr),
    .act_rdata (act_rdata),
    .wgt_re    (wgt_re),
    .wgt_addr  (wgt_addr),
    .wgt_rdata (wgt_rdata),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] act_fn(input logic [AW-1:0] a);
    return DW'(a * 7 + 32'h1001);
  endfunction

  function automatic logic [DW-1:0] wgt_fn(input logic [AW-1:0] a);
    return DW'(a * 13 + 32'h2003);
  endfunction

  // Synchronous memories; unread cycles return junk
  always @(posedge clk) begin
    act_rdata <= act_re ? act_fn(act_addr) : DW'($urandom);
    wgt_rdata <= wgt_re ? wgt_fn(wgt_addr) : DW'($urandom);
  end

  // Reference sequence straight from the loop nest
  logic          exp_re    [N];
  logic [AW-1:0] exp_aaddr [N];
  logic [AW-1:0] exp_waddr [N];
  logic [DW-1:0] exp_a     [N];
  logic [DW-1:0] exp_b     [N];

  task automatic build_model();
    int idx = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        for (int ci = 0; ci < CI; ci++)
          for (int co = 0; co < CO; co++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                int xx = x + kx - (K - 1) / 2;
                int yy = y + ky - (K - 1) / 2;
                bit inb = (xx >= 0) && (xx < W) && (yy >= 0) && (yy < H);
                exp_re[idx]    = inb;
                exp_aaddr[idx] = inb ? AW'((yy * W + xx) * CI + ci) : '0;
                exp_waddr[idx] = AW'(((co * CI + ci) * K + ky) * K + kx);
                exp_a[idx]     = inb ? act_fn(exp_aaddr[idx]) : '0;
                exp_b[idx]     = wgt_fn(exp_waddr[idx]);
                idx++;
              end
  endtask

  // Monitor state
  bit            mon_en = 1'b0;
  bit            rand_rdy = 1'b0;
  bit            seen_done;
  bit            prev_stall;
  logic [DW-1:0] prev_a, prev_b;
  int            issue_idx, xfer_idx, done_cnt, first_valid_cyc, last_xfer_cyc, start_cyc;

  // Ready driver
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      a_ready = 1'($urandom_range(0, 1));
      b_ready = ($urandom_range(0, 7) != 0);
    end else begin
      a_ready = 1'b1;
      b_ready = 1'b1;
    end
  end

  // Protocol and data monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      bit xfer;
      if (a_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (a_valid || b_valid) check("b_valid_eq", b_valid, a_valid);
      if (prev_stall) begin
        check("hold_valid", a_valid, 1);
        check("hold_a", a_data, prev_a);
        check("hold_b", b_data, prev_b);
      end
      xfer = a_valid && a_ready && b_ready;
      if (xfer) begin
        if (xfer_idx < N) begin
          check("a_data", a_data, exp_a[xfer_idx]);
          check("b_data", b_data, exp_b[xfer_idx]);
        end else begin
          check("extra_xfer", xfer_idx + 1, N);
        end
        xfer_idx++;
        last_xfer_cyc = cyc;
      end
      if (act_re || wgt_re) begin
        if (issue_idx < N) begin
          check("wgt_re", wgt_re, 1);
          check("act_re", act_re, exp_re[issue_idx]);
          check("wgt_addr", wgt_addr, exp_waddr[issue_idx]);
          if (exp_re[issue_idx]) check("act_addr", act_addr, exp_aaddr[issue_idx]);
        end else begin
          check("extra_issue", issue_idx + 1, N);
        end
        if (!busy) check("re_while_idle", busy, 1);
        issue_idx++;
        check("outstanding_le2", (issue_idx - xfer_idx) <= 2, 1);
      end
      prev_stall = a_valid && !xfer;
      prev_a     = a_data;
      prev_b     = b_data;
      if (done) begin
        check("done_latency", cyc, last_xfer_cyc + 1);
        check("done_xfers", xfer_idx, N);
        check("busy_at_done", busy, 0);
        done_cnt++;
        seen_done = 1'b1;
      end
    end
  end

  // One launch; stop_after>0 returns after that many transfers
  task automatic run(input bit rnd, input bit inject, input int stop_after);
    issue_idx = 0; xfer_idx = 0; done_cnt = 0; seen_done = 1'b0;
    first_valid_cyc = -1; last_xfer_cyc = -1; prev_stall = 1'b0;
    rand_rdy = rnd;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < 20000 && !seen_done && !(stop_after > 0 && xfer_idx >= stop_after); i++) begin
      @(posedge clk); #1;
      start = inject && (i == 40);
    end
    start = 1'b0;
    if (stop_after > 0) begin
      check("reached_stop", xfer_idx >= stop_after, 1);
    end else begin
      check("done_seen", seen_done, 1);
      check("first_valid", first_valid_cyc, start_cyc + 2);
      check("issue_total", issue_idx, N);
      if (!rnd) check("no_gap", last_xfer_cyc - first_valid_cyc, N - 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("single_done", done_cnt, 1);
      check("xfer_total", xfer_idx, N);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    build_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {busy, done, act_re, wgt_re, a_valid, b_valid}, 0);
    check("rst_addr", {act_addr, wgt_addr}, 0);
    check("rst_data", {a_data, b_data}, 0);
    @(posedge clk); #1;
    arst_n_in = 1'b1;

    run(1'b0, 1'b0, 0);
    run(1'b1, 1'b0, 0);
    run(1'b0, 1'b1, 0);

    // Asynchronous reset in the middle of a run
    run(1'b1, 1'b0, 100);
    mon_en = 1'b0;
    arst_n_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_ctrl", {busy, done, act_re, wgt_re, a_valid, b_valid}, 0);
      check("mid_rst_addr", {act_addr, wgt_addr}, 0);
      check("mid_rst_data", {a_data, b_data}, 0);
    end
    @(posedge clk); #1;
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {busy, done, wgt_re}, 0);
    run(1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
